// File: rtl/motor_step_gen.sv
// ============================================================================
// Module      : motor_step_gen
// Description : Step/direction pulse generator for a stepper driver.
//               Optional end-stop abort enabled by macro STEP_TERM_STOP_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module motor_step_gen #(
  parameter int DIR_SETUP = 25
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic        load,
  input  logic [14:0] divider,
  input  logic [11:0] stepsToGo,
  input  logic        dirInput,
  input  logic        term,
  output logic        step,
  output logic        dir,
  output logic        activeMode,
  output logic        done,
  output logic        stopped,
  output logic [11:0] remaining
);

  // A zero setup time would make the SETUP counter underflow, so clamp to 1.
  localparam int          c_SETUP_LEN = (DIR_SETUP < 1) ? 1 : DIR_SETUP;
  localparam logic [14:0] c_SETUP_CNT = 15'(c_SETUP_LEN - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    HIGH  = 2'd2,
    LOW   = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_stateNext;
  logic [14:0] r_cnt;
  logic [14:0] w_cntNext;
  logic [14:0] r_div;
  logic [14:0] w_divNext;
  logic [14:0] w_effDiv;
  logic [11:0] r_remaining;
  logic [11:0] w_remNext;
  logic [11:0] w_remDec;
  logic        r_dir;
  logic        w_dirNext;
  logic        r_done;
  logic        w_doneNext;
  logic        r_stopped;
  logic        w_stoppedNext;
  logic        w_termStop;

`ifdef STEP_TERM_STOP_EN
  logic r_termMeta;
  logic r_termSync;

  always_ff @(posedge CLK) begin
    if (reset) begin
      r_termMeta <= 1'b0;
      r_termSync <= 1'b0;
    end else begin
      r_termMeta <= ~term;
      r_termSync <= r_termMeta;
    end
  end

  // Only motion towards the end-stop (dir=0) is cut short.
  assign w_termStop = r_termSync & ~r_dir;
`else
  logic w_unusedTerm;
  assign w_unusedTerm = term;
  assign w_termStop   = 1'b0;
`endif

  assign w_effDiv = (divider == 15'd0) ? 15'd1 : divider;
  assign w_remDec = (r_remaining != 12'd0) ? (r_remaining - 12'd1) : 12'd0;

  always_comb begin
    w_stateNext   = r_state;
    w_cntNext     = r_cnt;
    w_divNext     = r_div;
    w_remNext     = r_remaining;
    w_dirNext     = r_dir;
    w_doneNext    = 1'b0;
    w_stoppedNext = r_stopped;
    case (r_state)
      IDLE: begin
        if (load) begin
          w_dirNext     = dirInput;
          w_remNext     = stepsToGo;
          w_divNext     = w_effDiv;
          w_stoppedNext = 1'b0;
          if (stepsToGo == 12'd0) begin
            w_doneNext = 1'b1;
          end else begin
            w_stateNext = SETUP;
            w_cntNext   = c_SETUP_CNT;
          end
        end
      end
      SETUP: begin
        if (w_termStop) begin
          w_stateNext   = IDLE;
          w_cntNext     = 15'd0;
          w_doneNext    = 1'b1;
          w_stoppedNext = 1'b1;
        end else if (r_cnt == 15'd0) begin
          w_stateNext = HIGH;
          w_cntNext   = r_div - 15'd1;
        end else begin
          w_cntNext = r_cnt - 15'd1;
        end
      end
      HIGH: begin
        // A pending abort waits for the high phase to finish so the pulse is never truncated.
        if (r_cnt == 15'd0) begin
          if (w_termStop) begin
            w_stateNext   = IDLE;
            w_cntNext     = 15'd0;
            w_doneNext    = 1'b1;
            w_stoppedNext = 1'b1;
          end else begin
            w_stateNext = LOW;
            w_cntNext   = r_div - 15'd1;
          end
        end else begin
          w_cntNext = r_cnt - 15'd1;
        end
      end
      LOW: begin
        if (w_termStop) begin
          w_stateNext   = IDLE;
          w_cntNext     = 15'd0;
          w_doneNext    = 1'b1;
          w_stoppedNext = 1'b1;
        end else if (r_cnt == 15'd0) begin
          w_remNext = w_remDec;
          if (w_remDec != 12'd0) begin
            w_stateNext = HIGH;
            w_cntNext   = r_div - 15'd1;
          end else begin
            w_stateNext = IDLE;
            w_cntNext   = 15'd0;
            w_doneNext  = 1'b1;
          end
        end else begin
          w_cntNext = r_cnt - 15'd1;
        end
      end
      default: begin
        w_stateNext = IDLE;
        w_cntNext   = 15'd0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      r_state     <= IDLE;
      r_cnt       <= 15'd0;
      r_div       <= 15'd0;
      r_remaining <= 12'd0;
      r_dir       <= 1'b0;
      r_done      <= 1'b0;
      r_stopped   <= 1'b0;
    end else begin
      r_state     <= w_stateNext;
      r_cnt       <= w_cntNext;
      r_div       <= w_divNext;
      r_remaining <= w_remNext;
      r_dir       <= w_dirNext;
      r_done      <= w_doneNext;
      r_stopped   <= w_stoppedNext;
    end
  end

  assign step       = (r_state == HIGH);
  assign activeMode = (r_state != IDLE);
  assign dir        = r_dir;
  assign done       = r_done;
  assign stopped    = r_stopped;
  assign remaining  = r_remaining;

endmodule

`default_nettype wire

// File: tb/tb_motor_step_gen.sv
// ============================================================================
// Module      : tb_motor_step_gen
// Description : Directed self-checking bench for motor_step_gen.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_motor_step_gen;

  logic        CLK;
  logic        reset;
  logic        load;
  logic [14:0] divider;
  logic [11:0] stepsToGo;
  logic        dirInput;
  logic        term;
  logic        step;
  logic        dir;
  logic        activeMode;
  logic        done;
  logic        stopped;
  logic [11:0] remaining;

  int errors = 0;
  int checks = 0;

  logic        capStep [0:255];
  logic        capAct  [0:255];
  logic        capDone [0:255];
  logic        capDir  [0:255];
  logic        capStop [0:255];
  logic [11:0] capRem  [0:255];

  motor_step_gen #(.DIR_SETUP(25)) dut (
    .CLK        (CLK),
    .reset      (reset),
    .load       (load),
    .divider    (divider),
    .stepsToGo  (stepsToGo),
    .dirInput   (dirInput),
    .term       (term),
    .step       (step),
    .dir        (dir),
    .activeMode (activeMode),
    .done       (done),
    .stopped    (stopped),
    .remaining  (remaining)
  );

  initial CLK = 1'b0;
  always #20 CLK = ~CLK;

  initial begin
    #(40 * 20000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Cycle 0 carries the load strobe; optional second load injected at cycle injAt.
  task automatic start_and_capture(input logic [14:0] div, input logic [11:0] n, input logic d,
                                   input int cycles, input int injAt, input logic [14:0] injDiv,
                                   input logic [11:0] injN, input logic injDir);
    @(posedge CLK); #1;
    divider = div; stepsToGo = n; dirInput = d; load = 1'b1;
    for (int c = 0; c < cycles; c++) begin
      @(negedge CLK);
      capStep[c] = step; capAct[c] = activeMode; capDone[c] = done;
      capDir[c] = dir; capStop[c] = stopped; capRem[c] = remaining;
      @(posedge CLK); #1;
      if (c + 1 == injAt) begin
        divider = injDiv; stepsToGo = injN; dirInput = injDir; load = 1'b1;
      end else begin
        load = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    checks++; if (step !== 1'b0) begin errors++; $display("FAIL reset_step got=%b exp=0", step); end
    checks++; if (dir !== 1'b0) begin errors++; $display("FAIL reset_dir got=%b exp=0", dir); end
    checks++; if (activeMode !== 1'b0) begin errors++; $display("FAIL reset_active got=%b exp=0", activeMode); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (stopped !== 1'b0) begin errors++; $display("FAIL reset_stopped got=%b exp=0", stopped); end
    checks++; if (remaining !== 12'd0) begin errors++; $display("FAIL reset_remaining got=%0d exp=0", remaining); end
    @(posedge CLK); #1;
    reset = 1'b0;
    repeat (2) @(posedge CLK);
  endtask

  // divider=4, 3 steps, dir=1: pulses 26-29, 34-37, 42-45; done at 50.
  task automatic test_single_train(input int injAt, input string tag);
    logic        expStep;
    logic [11:0] expRem;
    start_and_capture(15'd4, 12'd3, 1'b1, 60, injAt, 15'd7, 12'd9, 1'b0);
    for (int c = 1; c < 60; c++) begin
      expStep = (c >= 26 && c <= 29) || (c >= 34 && c <= 37) || (c >= 42 && c <= 45);
      expRem  = (c < 34) ? 12'd3 : (c < 42) ? 12'd2 : (c < 50) ? 12'd1 : 12'd0;
      checks++; if (capStep[c] !== expStep) begin errors++; $display("FAIL %s_step c=%0d got=%b exp=%b", tag, c, capStep[c], expStep); end
      checks++; if (capDone[c] !== (c == 50)) begin errors++; $display("FAIL %s_done c=%0d got=%b exp=%b", tag, c, capDone[c], (c == 50)); end
      checks++; if (capAct[c] !== (c <= 49)) begin errors++; $display("FAIL %s_active c=%0d got=%b exp=%b", tag, c, capAct[c], (c <= 49)); end
      checks++; if (capRem[c] !== expRem) begin errors++; $display("FAIL %s_remaining c=%0d got=%0d exp=%0d", tag, c, capRem[c], expRem); end
      checks++; if (capDir[c] !== 1'b1) begin errors++; $display("FAIL %s_dir c=%0d got=%b exp=1", tag, c, capDir[c]); end
    end
  endtask

  // divider=0 behaves as 1: pulses at 26 and 28, done at 30.
  task automatic test_divider_zero();
    logic [11:0] expRem;
    start_and_capture(15'd0, 12'd2, 1'b0, 35, -1, 15'd0, 12'd0, 1'b0);
    for (int c = 1; c < 35; c++) begin
      expRem = (c < 28) ? 12'd2 : (c < 30) ? 12'd1 : 12'd0;
      checks++; if (capStep[c] !== (c == 26 || c == 28)) begin errors++; $display("FAIL div0_step c=%0d got=%b exp=%b", c, capStep[c], (c == 26 || c == 28)); end
      checks++; if (capDone[c] !== (c == 30)) begin errors++; $display("FAIL div0_done c=%0d got=%b exp=%b", c, capDone[c], (c == 30)); end
      checks++; if (capRem[c] !== expRem) begin errors++; $display("FAIL div0_remaining c=%0d got=%0d exp=%0d", c, capRem[c], expRem); end
      checks++; if (capDir[c] !== 1'b0) begin errors++; $display("FAIL div0_dir c=%0d got=%b exp=0", c, capDir[c]); end
    end
  endtask

  task automatic test_zero_steps();
    start_and_capture(15'd5, 12'd0, 1'b1, 6, -1, 15'd0, 12'd0, 1'b0);
    for (int c = 1; c < 6; c++) begin
      checks++; if (capDone[c] !== (c == 1)) begin errors++; $display("FAIL zero_done c=%0d got=%b exp=%b", c, capDone[c], (c == 1)); end
      checks++; if (capAct[c] !== 1'b0) begin errors++; $display("FAIL zero_active c=%0d got=%b exp=0", c, capAct[c]); end
      checks++; if (capStep[c] !== 1'b0) begin errors++; $display("FAIL zero_step c=%0d got=%b exp=0", c, capStep[c]); end
      checks++; if (capRem[c] !== 12'd0) begin errors++; $display("FAIL zero_remaining c=%0d got=%0d exp=0", c, capRem[c]); end
    end
  endtask

  // Second load lands on the done cycle (30) and must start a new command.
  task automatic test_back_to_back();
    logic [11:0] expRem;
    start_and_capture(15'd2, 12'd1, 1'b1, 60, 30, 15'd1, 12'd1, 1'b0);
    for (int c = 1; c < 60; c++) begin
      expRem = (c < 30) ? 12'd1 : (c == 30) ? 12'd0 : (c < 58) ? 12'd1 : 12'd0;
      checks++; if (capStep[c] !== (c == 26 || c == 27 || c == 56)) begin errors++; $display("FAIL b2b_step c=%0d got=%b", c, capStep[c]); end
      checks++; if (capDone[c] !== (c == 30 || c == 58)) begin errors++; $display("FAIL b2b_done c=%0d got=%b", c, capDone[c]); end
      checks++; if (capAct[c] !== (c != 30 && c < 58)) begin errors++; $display("FAIL b2b_active c=%0d got=%b", c, capAct[c]); end
      checks++; if (capRem[c] !== expRem) begin errors++; $display("FAIL b2b_remaining c=%0d got=%0d exp=%0d", c, capRem[c], expRem); end
      checks++; if (capDir[c] !== (c <= 30)) begin errors++; $display("FAIL b2b_dir c=%0d got=%b exp=%b", c, capDir[c], (c <= 30)); end
    end
  endtask

  task automatic test_reset_mid_pulse();
    start_and_capture(15'd4, 12'd3, 1'b1, 35, -1, 15'd0, 12'd0, 1'b0);
    checks++; if (capStep[34] !== 1'b1) begin errors++; $display("FAIL rstmid_pre_step got=%b exp=1", capStep[34]); end
    reset = 1'b1;
    @(posedge CLK); #1;
    reset = 1'b0;
    @(negedge CLK);
    checks++; if (step !== 1'b0) begin errors++; $display("FAIL rstmid_step got=%b exp=0", step); end
    checks++; if (activeMode !== 1'b0) begin errors++; $display("FAIL rstmid_active got=%b exp=0", activeMode); end
    checks++; if (remaining !== 12'd0) begin errors++; $display("FAIL rstmid_remaining got=%0d exp=0", remaining); end
    for (int k = 0; k < 4; k++) begin
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL rstmid_done k=%0d got=%b exp=0", k, done); end
      @(negedge CLK);
    end
    start_and_capture(15'd1, 12'd1, 1'b1, 30, -1, 15'd0, 12'd0, 1'b0);
    for (int c = 1; c < 30; c++) begin
      checks++; if (capStep[c] !== (c == 26)) begin errors++; $display("FAIL rstmid_rerun_step c=%0d got=%b", c, capStep[c]); end
      checks++; if (capDone[c] !== (c == 28)) begin errors++; $display("FAIL rstmid_rerun_done c=%0d got=%b", c, capDone[c]); end
    end
  endtask

`ifdef STEP_TERM_STOP_EN
  task automatic test_term_stop();
    int   idleK;
    int   doneCyc;
    int   pulses;
    logic prevStep;
    // Step 6 LOW spans cycles 136-145; term drops at cycle 138.
    start_and_capture(15'd10, 12'd100, 1'b0, 138, -1, 15'd0, 12'd0, 1'b0);
    checks++; if (capRem[137] !== 12'd95) begin errors++; $display("FAIL term_pre_remaining got=%0d exp=95", capRem[137]); end
    term = 1'b0;
    idleK = -1;
    for (int k = 0; k < 8; k++) begin
      @(negedge CLK);
      if (activeMode === 1'b0) begin idleK = k; break; end
      @(posedge CLK); #1;
    end
    checks++; if (idleK < 1 || idleK > 3) begin errors++; $display("FAIL term_latency got=%0d exp=1..3", idleK); end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL term_done got=%b exp=1", done); end
    checks++; if (stopped !== 1'b1) begin errors++; $display("FAIL term_stopped got=%b exp=1", stopped); end
    checks++; if (remaining !== 12'd95) begin errors++; $display("FAIL term_remaining got=%0d exp=95", remaining); end
    @(negedge CLK);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL term_done_pulse got=%b exp=0", done); end
    checks++; if (stopped !== 1'b1) begin errors++; $display("FAIL term_stopped_hold got=%b exp=1", stopped); end
    // Load towards a closed end-stop: accepted, then aborts from SETUP.
    start_and_capture(15'd3, 12'd7, 1'b0, 4, -1, 15'd0, 12'd0, 1'b0);
    checks++; if (capAct[1] !== 1'b1 || capStop[1] !== 1'b0) begin errors++; $display("FAIL term_reload_c1 active=%b stopped=%b exp=1,0", capAct[1], capStop[1]); end
    checks++; if (capAct[2] !== 1'b0 || capDone[2] !== 1'b1 || capStop[2] !== 1'b1) begin errors++; $display("FAIL term_reload_c2 active=%b done=%b stopped=%b exp=0,1,1", capAct[2], capDone[2], capStop[2]); end
    checks++; if (capRem[2] !== 12'd7) begin errors++; $display("FAIL term_reload_remaining got=%0d exp=7", capRem[2]); end
    // Away from the end-stop the full command runs: done at 26+100*20.
    start_and_capture(15'd10, 12'd100, 1'b1, 2, -1, 15'd0, 12'd0, 1'b0);
    pulses = 0; prevStep = 1'b0; doneCyc = -1;
    for (int c = 2; c < 2200; c++) begin
      @(negedge CLK);
      if (step === 1'b1 && prevStep === 1'b0) pulses++;
      prevStep = step;
      if (done === 1'b1) begin doneCyc = c; break; end
      @(posedge CLK); #1;
    end
    checks++; if (doneCyc !== 2026) begin errors++; $display("FAIL term_dir1_done_cycle got=%0d exp=2026", doneCyc); end
    checks++; if (pulses !== 100) begin errors++; $display("FAIL term_dir1_pulses got=%0d exp=100", pulses); end
    checks++; if (stopped !== 1'b0 || remaining !== 12'd0) begin errors++; $display("FAIL term_dir1_end stopped=%b remaining=%0d exp=0,0", stopped, remaining); end
    term = 1'b1;
    repeat (4) @(posedge CLK);
    #1;
  endtask
`else
  task automatic test_term_ignored();
    term = 1'b0;
    start_and_capture(15'd0, 12'd2, 1'b0, 35, -1, 15'd0, 12'd0, 1'b0);
    for (int c = 1; c < 35; c++) begin
      checks++; if (capStep[c] !== (c == 26 || c == 28)) begin errors++; $display("FAIL termign_step c=%0d got=%b", c, capStep[c]); end
      checks++; if (capDone[c] !== (c == 30)) begin errors++; $display("FAIL termign_done c=%0d got=%b", c, capDone[c]); end
      checks++; if (capStop[c] !== 1'b0) begin errors++; $display("FAIL termign_stopped c=%0d got=%b exp=0", c, capStop[c]); end
    end
    term = 1'b1;
  endtask
`endif

  initial begin
    reset = 1'b1; load = 1'b0; divider = 15'd0; stepsToGo = 12'd0;
    dirInput = 1'b0; term = 1'b1;
    test_reset();
    test_single_train(-1, "train");
    test_divider_zero();
    test_zero_steps();
    test_single_train(30, "ignload");
    test_back_to_back();
    test_reset_mid_pulse();
`ifdef STEP_TERM_STOP_EN
    test_term_stop();
`else
    test_term_ignored();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/motor_step_gen.md
MOTOR_STEP_GEN -- requirements
Module: motor_step_gen

Interface
REQ-001 Parameter DIR_SETUP, default 25: clock cycles between dir update and first step rising edge (1 us at 25 MHz).
REQ-002 CLK  input  1  system clock, 25 MHz; all logic on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 load  input  1  single-cycle command strobe from the UART command decoder.
REQ-005 divider  input  15  half-period of step, in CLK cycles.
REQ-006 stepsToGo  input  12  number of step pulses to issue.
REQ-007 dirInput  input  1  requested direction.
REQ-008 term  input  1  end-stop switch, active-low, asynchronous to CLK.
REQ-009 step  output  1  step pulse to driver.
REQ-010 dir  output  1  direction to driver.
REQ-011 activeMode  output  1  high while a command executes.
REQ-012 done  output  1  one-cycle pulse on command completion or abort.
REQ-013 stopped  output  1  high after an end-stop abort until the next accepted load.
REQ-014 remaining  output  12  steps not yet completed.

Function
REQ-015 FSM states: IDLE, SETUP, HIGH, LOW.
REQ-016 load SHALL be accepted only in IDLE; load in any other state is ignored, with no change to the latched command.
REQ-017 Accepted load SHALL latch dir<=dirInput, remaining<=stepsToGo, the effective divider (divider==0 treated as 1), and clear stopped.
REQ-018 Accepted load with stepsToGo==0: stays IDLE, activeMode stays 0, done pulses the next cycle.
REQ-019 Accepted load with stepsToGo>0 at cycle 0: SETUP and activeMode=1 from cycle 1.
REQ-020 SETUP SHALL last DIR_SETUP cycles; step rises at cycle 1+DIR_SETUP.
REQ-021 HIGH: step=1 for exactly the effective divider cycles, then LOW.
REQ-022 LOW: step=0 for exactly the effective divider cycles.
REQ-022a On the last LOW cycle, remaining decrements by 1.
REQ-022b After that decrement, the FSM goes to HIGH if the new remaining value is non-zero, otherwise to IDLE.
REQ-023 Completion: on the cycle IDLE is re-entered, activeMode=0 and done=1 for one cycle; remaining=0.
REQ-024 Step period = 2*effective divider cycles; no extra cycle between consecutive pulses.
REQ-025 Down-counters are 15-bit and remaining is 12-bit; no wrap-around SHALL occur (remaining never decrements below 0).
REQ-026 dir SHALL not change while activeMode=1.
REQ-027 done and load in the same cycle: the load is accepted (FSM already IDLE).

Reset
REQ-028 reset SHALL force IDLE and step=0, dir=0, activeMode=0, done=0, stopped=0, remaining=0, and clear the counters and synchronizer flops.
REQ-029 reset mid-pulse SHALL drop step to 0 on the next edge; no done pulse is generated.
REQ-030 reset has priority over load in the same cycle.

Configuration
REQ-031 Macro STEP_TERM_STOP_EN.
REQ-031a When defined, term passes through a 2-flop synchronizer; termSync=~term after sync.
REQ-031b If termSync=1 and dir=0 in SETUP or LOW: go IDLE next cycle, done=1, stopped=1; remaining holds its value.
REQ-031c If termSync=1 and dir=0 in HIGH: the current high period completes, then abort as in REQ-031b without LOW.
REQ-031d Motion with dir=1 is unaffected by term.
REQ-031e A load with dirInput=0 while termSync=1 is accepted, then aborts from SETUP.
REQ-032 When not defined, term is ignored, stopped is tied 0, and no synchronizer is built.

Verification
REQ-033 load with divider=4, stepsToGo=3, dirInput=1 -> dir=1 at cycle 1; step high on cycles 26-29, 34-37, 42-45; done at cycle 50; remaining 3->2->1->0.
REQ-034 load with divider=0, stepsToGo=2 -> treated as divider=1; step high on cycles 26 and 28; done at cycle 30.
REQ-035 load with stepsToGo=0 -> done pulse at cycle 1, activeMode never asserts, step stays 0.
REQ-036 Second load with different values at cycle 30 of an active command -> ignored; original pulse train and remaining unchanged.
REQ-037 With STEP_TERM_STOP_EN: dirInput=0, divider=10, stepsToGo=100; drive term low mid-LOW after 5 steps -> IDLE within 3 cycles, done=1, stopped=1, remaining=95. Repeat with dirInput=1 -> all 100 steps.
REQ-038 reset asserted during HIGH of step 2 -> next cycle step=0, activeMode=0, remaining=0, no done; subsequent load runs normally.
